// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an 8-bit synchronous FIFO and serialises each
// one as a UART frame (start, 8 data bits LSB-first, optional even parity,
// one or two stop bits).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift_reg, shift_reg_n;
  logic             parity_acc, parity_acc_n;
  logic             tx_n;
  logic             rd_en_n;
  logic             frame_done_n;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_MAX);
  assign busy    = (state != IDLE);

  // State, counters, data path and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_acc <= 1'b0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_idx    <= bit_idx_n;
      shift_reg  <= shift_reg_n;
      parity_acc <= parity_acc_n;
      tx         <= tx_n;
      fifo_rd_en <= rd_en_n;
      frame_done <= frame_done_n;
    end
  end

  // Next-state, counter and next-output logic. Registered outputs are derived
  // from the next state so tx/fifo_rd_en change on the same edge as the state.
  always_comb begin
    state_n      = state;
    baud_cnt_n   = baud_cnt;
    bit_idx_n    = bit_idx;
    shift_reg_n  = shift_reg;
    parity_acc_n = parity_acc;

    unique case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (!fifo_empty) state_n = FETCH;
      end
      FETCH: begin
        baud_cnt_n = '0;
        state_n    = LATCH;
      end
      LATCH: begin
        baud_cnt_n   = '0;
        bit_idx_n    = '0;
        shift_reg_n  = fifo_data;
        parity_acc_n = ^fifo_data;
        state_n      = START;
      end
      START: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_n   = bit_idx + 3'd1;
            shift_reg_n = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = STOP;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = '0;
            state_n   = IDLE;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_reg_n[0];
      PARITY:  tx_n = parity_acc_n;
      default: tx_n = 1'b1;
    endcase

    rd_en_n      = (state_n == FETCH);
    frame_done_n = (state == STOP) && (state_n == IDLE);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two instances (8N1 and 8E2 at 4 clocks/bit) fed by bench
// FIFOs; a frame-level model predicts every output each cycle, and directed
// captures pin latency, bit values, frame length, gaps and reset behaviour.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int WN  = 512;

  typedef struct packed {
    logic tx;
    logic busy;
    logic rd;
    logic fd;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty [2];
  logic [7:0] fifo_data  [2];
  logic       rd_en      [2];
  logic       tx         [2];
  logic       busy       [2];
  logic       fdone      [2];

  logic [7:0]  mem [2][64];
  int unsigned push_cnt [2] = '{0, 0};
  int unsigned pop_cnt  [2] = '{0, 0};
  logic        bad_read [2] = '{1'b0, 1'b0};

  exp_t       expq [2][$];
  logic [7:0] bq   [2][$];

  logic w_tx   [2][WN];
  logic w_busy [2][WN];
  logic w_rd   [2][WN];
  logic w_fd   [2][WN];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign fifo_empty[0] = (push_cnt[0] == pop_cnt[0]);
  assign fifo_empty[1] = (push_cnt[1] == pop_cnt[1]);

  // Bench FIFOs: data appears the cycle after a read is sampled; never reset.
  always @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (rd_en[ch]) begin
        if (push_cnt[ch] == pop_cnt[ch]) bad_read[ch] <= 1'b1;
        else begin
          fifo_data[ch] <= mem[ch][pop_cnt[ch] % 64];
          pop_cnt[ch]   <= pop_cnt[ch] + 1;
        end
      end
    end
  end

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
    .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(fdone[0])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
    .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(fdone[1])
  );

  function automatic int par_en(int ch);
    return (ch == 1) ? 1 : 0;
  endfunction

  function automatic int stop_bits(int ch);
    return (ch == 1) ? 2 : 1;
  endfunction

  function automatic int frame_cycles(int ch);
    return (1 + 8 + par_en(ch) + stop_bits(ch)) * CPB;
  endfunction

  function automatic exp_t mk(logic t, logic b, logic r, logic f);
    exp_t e;
    e.tx = t; e.busy = b; e.rd = r; e.fd = f;
    return e;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Frame expectation from the bit list: FETCH, LATCH, bit cells, done slot.
  task automatic build_frame(input int ch, input logic [7:0] b);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par_en(ch) != 0) bits.push_back(^b);
    for (int i = 0; i < stop_bits(ch); i++) bits.push_back(1'b1);
    expq[ch].push_back(mk(1'b1, 1'b1, 1'b1, 1'b0));
    expq[ch].push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    foreach (bits[i])
      for (int c = 0; c < CPB; c++) expq[ch].push_back(mk(bits[i], 1'b1, 1'b0, 1'b0));
    expq[ch].push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic monitor_step();
    exp_t       e;
    exp_t       act;
    logic [7:0] b;
    for (int ch = 0; ch < 2; ch++) begin
      if (reset) begin
        expq[ch].delete();
        e = mk(1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        if (expq[ch].size() == 0) e = mk(1'b1, 1'b0, 1'b0, 1'b0);
        else e = expq[ch].pop_front();
        if (!e.busy && !fifo_empty[ch] && bq[ch].size() != 0) begin
          b = bq[ch].pop_front();
          build_frame(ch, b);
        end
      end
      act = mk(tx[ch], busy[ch], rd_en[ch], fdone[ch]);
      check(act == e, $sformatf("cycle_ch%0d_{tx,busy,rd,fd}", ch), 32'(act), 32'(e));
    end
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    mem[ch][push_cnt[ch] % 64] = b;
    push_cnt[ch] = push_cnt[ch] + 1;
    bq[ch].push_back(b);
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        w_tx[ch][k]   = tx[ch];
        w_busy[ch][k] = busy[ch];
        w_rd[ch][k]   = rd_en[ch];
        w_fd[ch][k]   = fdone[ch];
      end
    end
  endtask

  // kind 0: tx low, 1: fifo_rd_en high, 2: frame_done high
  function automatic int find(int ch, int kind, int from, int n);
    for (int k = (from < 0 ? 0 : from); k < n; k++) begin
      if (kind == 0 && !w_tx[ch][k]) return k;
      if (kind == 1 && w_rd[ch][k]) return k;
      if (kind == 2 && w_fd[ch][k]) return k;
    end
    return -1;
  endfunction

  function automatic int count(int ch, int kind, int n);
    int c = 0;
    for (int k = 0; k < n; k++) begin
      if (kind == 1 && w_rd[ch][k]) c++;
      if (kind == 2 && w_fd[ch][k]) c++;
    end
    return c;
  endfunction

  function automatic logic [7:0] decode(int ch, int f);
    logic [7:0] d = '0;
    for (int i = 0; i < 8; i++)
      if (f + CPB * (i + 1) + 2 < WN) d[i] = w_tx[ch][f + CPB * (i + 1) + 2];
    return d;
  endfunction

  initial begin
    int         f, fd, nf, nrd;
    logic [9:0] bits;
    logic [7:0] seq [4];
    bit         ok;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    check(frame_cycles(0) == 40, "model_len_8n1", frame_cycles(0), 40);
    check(frame_cycles(1) == 48, "model_len_8e2", frame_cycles(1), 48);

    // Reset held with FIFO empty
    repeat (5) @(negedge clk);
    check(tx[0] == 1'b1, "rst_tx", tx[0], 1);
    check(busy[0] == 1'b0, "rst_busy", busy[0], 0);
    check(rd_en[0] == 1'b0, "rst_rd_en", rd_en[0], 0);
    check(fdone[0] == 1'b0, "rst_frame_done", fdone[0], 0);
    @(posedge clk); #1 reset = 1'b0;
    nrd = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rd_en[0] || rd_en[1]) nrd++;
    end
    check(nrd == 0, "no_read_when_empty", nrd, 0);

    // Single byte 0xA1: latency, bit pattern, frame length
    @(posedge clk); #1 push(0, 8'hA1);
    capture(60);
    check(find(0, 1, 0, 60) == 1, "a1_rd_latency", find(0, 1, 0, 60), 1);
    check(count(0, 1, 60) == 1, "a1_rd_pulses", count(0, 1, 60), 1);
    f = find(0, 0, 0, 60);
    check(f == 3, "a1_tx_latency", f, 3);
    if (f < 0) f = 0;
    for (int i = 0; i < 10; i++) bits[i] = w_tx[0][f + CPB * i + 2];
    check(bits == {1'b1, 8'hA1, 1'b0}, "a1_bits", bits, {1'b1, 8'hA1, 1'b0});
    check(find(0, 2, 0, 60) == 43, "a1_done_cycle", find(0, 2, 0, 60), 43);
    check(count(0, 2, 60) == 1, "a1_done_pulses", count(0, 2, 60), 1);
    ok = !w_busy[0][0] && !w_busy[0][43];
    for (int k = 1; k <= 42; k++) if (!w_busy[0][k]) ok = 1'b0;
    check(ok, "a1_busy_span", ok, 1);

    // Back-to-back A1,B2,C3,C4
    seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3; seq[3] = 8'hC4;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(0, seq[i]);
    capture(200);
    check(count(0, 1, 200) == 4, "b2b_rd_pulses", count(0, 1, 200), 4);
    f = find(0, 0, 0, 200);
    if (f < 0) f = 0;
    for (int i = 0; i < 4; i++) begin
      check(decode(0, f) == seq[i], $sformatf("b2b_byte%0d", i), decode(0, f), seq[i]);
      fd = find(0, 2, f, 200);
      check(fd - f == 40, $sformatf("b2b_len%0d", i), fd - f, 40);
      if (i < 3) begin
        nf = find(0, 0, fd, 200);
        check(nf - fd == 3, $sformatf("b2b_gap%0d", i), nf - fd, 3);
        f = (nf < 0) ? 0 : nf;
      end
    end

    // Even parity, two stop bits: C3 -> parity 0, C4 -> parity 1
    @(posedge clk); #1 push(1, 8'hC3); push(1, 8'hC4);
    capture(120);
    f = find(1, 0, 0, 120);
    check(f == 3, "par_tx_latency", f, 3);
    if (f < 0) f = 0;
    for (int i = 0; i < 2; i++) begin
      check(decode(1, f) == seq[2+i], $sformatf("par_byte%0d", i), decode(1, f), seq[2+i]);
      check(w_tx[1][f + 38] == 1'(i), $sformatf("par_bit%0d", i), w_tx[1][f + 38], i);
      ok = 1'b1;
      for (int k = 40; k < 48; k++) if (!w_tx[1][f + k]) ok = 1'b0;
      check(ok, $sformatf("par_stop%0d", i), ok, 1);
      fd = find(1, 2, f, 120);
      check(fd - f == 48, $sformatf("par_len%0d", i), fd - f, 48);
      nf = find(1, 0, fd, 120);
      f = (nf < 0) ? 0 : nf;
    end

    // Reset inside the third data bit of 0xB2 with 0xC3 queued
    @(posedge clk); #1 push(0, 8'hB2); push(0, 8'hC3);
    repeat (17) @(negedge clk);
    check(tx[0] == 1'b0, "rst_mid_bit2", tx[0], 0);
    #1 reset = 1'b1;
    #1;
    check(tx[0] == 1'b1, "rst_mid_tx_async", tx[0], 1);
    check(busy[0] == 1'b0, "rst_mid_busy", busy[0], 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    capture(60);
    f = find(0, 0, 0, 60);
    check(f == 3, "after_rst_latency", f, 3);
    if (f < 0) f = 0;
    check(decode(0, f) == 8'hC3, "after_rst_byte", decode(0, f), 8'hC3);
    check(count(0, 2, 60) == 1, "after_rst_done", count(0, 2, 60), 1);

    check(!bad_read[0] && !bad_read[1], "never_read_empty", bad_read[0] | bad_read[1], 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
